// File: rtl/pol_pkg.sv
// Shared types and constants for the pooling/activation stage.
// Optional leaky activation is selected by POL_LEAKY_EN.
package pol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } pol_state_e;

    localparam logic POL_MAX = 1'b0;
    localparam logic POL_AVG = 1'b1;

    localparam int MODE_BIT = 2;
    localparam int WIN_LSB  = 0;
    localparam int WIN_MSB  = 1;
    localparam int WIN_BITS = WIN_MSB - WIN_LSB + 1;

    localparam int LEAKY_SHIFT = 3;

    // Window exponent limited to what the accumulator was sized for.
    function automatic logic [WIN_BITS-1:0] win_clamp(input logic [WIN_BITS-1:0] s,
                                                      input int unsigned wmax);
        logic [WIN_BITS-1:0] r;
        r = s;
        if (int'(s) > int'(wmax))
            r = wmax[WIN_BITS-1:0];
        return r;
    endfunction

endpackage

// File: rtl/pol_lane.sv
// One lane: max/sum accumulator, pooling result and (leaky, if POL_LEAKY_EN) ReLU.
// Sequencing comes from pol_unit; the lane only reacts to take/first/done.
module pol_lane
    import pol_pkg::*;
#(
    parameter int DW        = 16,
    parameter int WMAX_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                take_i,
    input  logic                first_i,
    input  logic                done_i,
    input  logic                avg_i,
    input  logic [WIN_BITS-1:0] shift_i,
    input  logic                act_i,
    input  logic [DW-1:0]       q_i,
    output logic [DW-1:0]       y_o
);

    localparam int SW = DW + WMAX_LOG2;

    logic signed [SW-1:0] sx;
    logic signed [SW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] pooled;
    logic signed [DW-1:0] act;
    logic        [DW-1:0] y_q;

    assign sx = {{WMAX_LOG2{q_i[DW-1]}}, q_i};

    always_comb begin
        acc_d = acc_q;
        if (first_i)
            acc_d = sx;
        else if (avg_i)
            acc_d = acc_q + sx;
        else if (sx > acc_q)
            acc_d = sx;

        // Shifted sum is guaranteed to fit DW, so the truncation is exact.
        pooled = avg_i ? DW'(acc_d >>> shift_i) : DW'(acc_d);

        act = pooled;
        if (act_i && pooled[DW-1]) begin
`ifdef POL_LEAKY_EN
            act = pooled >>> LEAKY_SHIFT;
`else
            act = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (take_i)
                acc_q <= acc_d;
            if (done_i)
                y_q <= act;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pol_unit.sv
// Windowed max/avg pooling with optional ReLU over CH lanes, valid/ready on both sides.
// Define POL_LEAKY_EN to make the activation a leaky ReLU (slope 1/8).
module pol_unit
    import pol_pkg::*;
#(
    parameter int DW        = 16,
    parameter int CH        = 1,
    parameter int WMAX_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 epol,
    input  logic                 eact,
    input  logic [2:0]           pol_s,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DW-1:0]     q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DW-1:0]     y,
    output logic [WMAX_LOG2:0]   win_cnt
);

    localparam logic [WMAX_LOG2:0] CNT_ONE = (WMAX_LOG2+1)'(1);

    pol_state_e           state_q;
    logic [WMAX_LOG2:0]   win_cnt_q;
    logic                 valid_q;
    logic                 lat_epol_q;
    logic                 lat_eact_q;
    logic [2:0]           lat_pols_q;

    logic                 first;
    logic                 fire;
    logic                 done;
    logic                 cfg_epol;
    logic                 cfg_eact;
    logic [2:0]           cfg_pols;
    logic [WIN_BITS-1:0]  cfg_shift;
    logic                 cfg_avg;
    logic [WMAX_LOG2:0]   cfg_w;
    logic [WMAX_LOG2:0]   cnt_d;

    assign in_ready = ~rst & (state_q != OUT);
    assign first    = (state_q == IDLE);
    // clr takes priority over a simultaneous accept: the sample is dropped.
    assign fire     = in_valid & in_ready & ~clr;

    // Live config on the window's first accept, latched config afterwards.
    always_comb begin
        cfg_epol  = first ? epol  : lat_epol_q;
        cfg_eact  = first ? eact  : lat_eact_q;
        cfg_pols  = first ? pol_s : lat_pols_q;
        cfg_shift = cfg_epol ? win_clamp(cfg_pols[WIN_MSB:WIN_LSB], WMAX_LOG2) : '0;
        cfg_avg   = cfg_epol & (cfg_pols[MODE_BIT] == POL_AVG);
        cfg_w     = CNT_ONE << cfg_shift;
        cnt_d     = first ? CNT_ONE : win_cnt_q + CNT_ONE;
        done      = fire & (cnt_d == cfg_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            valid_q    <= 1'b0;
            lat_epol_q <= 1'b0;
            lat_eact_q <= 1'b0;
            lat_pols_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, ACC: begin
                    if (clr) begin
                        state_q   <= IDLE;
                        win_cnt_q <= '0;
                    end else if (fire) begin
                        lat_epol_q <= cfg_epol;
                        lat_eact_q <= cfg_eact;
                        lat_pols_q <= cfg_pols;
                        win_cnt_q  <= cnt_d;
                        state_q    <= done ? OUT : ACC;
                        valid_q    <= done;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        win_cnt_q <= '0;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    win_cnt_q <= '0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign win_cnt   = win_cnt_q;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        pol_lane #(
            .DW        (DW),
            .WMAX_LOG2 (WMAX_LOG2)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .take_i  (fire),
            .first_i (first),
            .done_i  (done),
            .avg_i   (cfg_avg),
            .shift_i (cfg_shift),
            .act_i   (cfg_eact),
            .q_i     (q[k*DW +: DW]),
            .y_o     (y[k*DW +: DW])
        );
    end

endmodule

// File: tb/tb_pol_unit.sv
// Self-checking bench for pol_unit (DW=16, CH=2, WMAX_LOG2=3); expected results
// are queued per window and compared whenever a result is handed off.
module tb_pol_unit;

    localparam int DW = 16;
    localparam int CH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              epol = 1'b0;
    logic              eact = 1'b0;
    logic [2:0]        pol_s = 3'b000;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*DW-1:0]  q = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CH*DW-1:0]  y;
    logic [3:0]        win_cnt;

    int total = 0;
    int bad   = 0;
    logic [CH*DW-1:0] exp_q[$];
    logic [CH*DW-1:0] mon_exp;

    pol_unit #(.DW(16), .CH(2), .WMAX_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .epol      (epol),
        .eact      (eact),
        .pol_s     (pol_s),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handed-off result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h want=none", y);
            end else begin
                mon_exp = exp_q.pop_front();
                if (y !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_result got=%h want=%h", y, mon_exp);
                end
            end
        end
    end

    function automatic logic [15:0] model(input int s[8], input int n, input bit ep,
                                          input bit ea, input logic [2:0] ps);
        int v;
        int lg;
        logic [1:0] wf;
        wf = ps[1:0];
        lg = ep ? int'(wf) : 0;
        if (lg > 3) lg = 3;
        if (ep && ps[2]) begin
            v = 0;
            for (int i = 0; i < n; i++) v += s[i];
            v = v >>> lg;
        end else begin
            v = s[0];
            for (int i = 1; i < n; i++) if (s[i] > v) v = s[i];
        end
        if (ea && v < 0) begin
`ifdef POL_LEAKY_EN
            v = v >>> 3;
`else
            v = 0;
`endif
        end
        return 16'(v);
    endfunction

    task automatic push_exp(input int a[8], input int b[8], input int n);
        exp_q.push_back({model(b, n, epol, eact, pol_s), model(a, n, epol, eact, pol_s)});
    endtask

    task automatic send(input int a, input int b);
        int guard;
        guard = 0;
        q = {16'(b), 16'(a)};
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (y !== '0) begin bad++; $display("FAIL rst_y got=%h want=0", y); end
        total++; if (win_cnt !== 4'd0) begin bad++; $display("FAIL rst_win_cnt got=%0d want=0", win_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_max_w4();
        int a[8];
        int b[8];
        a = '{5, -3, 12, 7, 0, 0, 0, 0};
        b = '{-1, -2, -7, -9, 0, 0, 0, 0};
        epol = 1'b1; eact = 1'b0; pol_s = 3'b010;
        push_exp(a, b, 4);
        for (int i = 0; i < 4; i++) begin
            send(a[i], b[i]);
            total++; if (win_cnt !== 4'(i + 1)) begin bad++; $display("FAIL max_win_cnt got=%0d want=%0d", win_cnt, i + 1); end
            total++; if (out_valid !== (i == 3)) begin bad++; $display("FAIL max_latency got=%b want=%b", out_valid, (i == 3)); end
        end
        total++; if (y[15:0] !== 16'd12) begin bad++; $display("FAIL max_y0 got=%h want=000c", y[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_avg_relu();
        int a[8];
        int b[8];
        a = '{-8, -4, 2, 1, 0, 0, 0, 0};
        b = '{100, 3, 5, -1, 0, 0, 0, 0};
        for (int r = 0; r < 2; r++) begin
            epol = 1'b1; eact = (r == 0); pol_s = 3'b110;
            push_exp(a, b, 4);
            for (int i = 0; i < 4; i++) send(a[i], b[i]);
            total++;
            if (y[15:0] !== ((r == 0) ? 16'h0000 : 16'hFFFD)) begin
                bad++; $display("FAIL avg_y0 eact=%0d got=%h", eact, y[15:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int a[8];
        int b[8];
        logic [CH*DW-1:0] hold;
        a = '{-20, 0, 0, 0, 0, 0, 0, 0};
        b = '{7, 0, 0, 0, 0, 0, 0, 0};
        epol = 1'b0; eact = 1'b1; pol_s = 3'b010;
        out_ready = 1'b0;
        push_exp(a, b, 1);
        hold = {model(b, 1, 1'b0, 1'b1, 3'b010), model(a, 1, 1'b0, 1'b1, 3'b010)};
        send(-20, 7);
        in_valid = 1'b1; q = {16'd55, 16'd55};
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            total++; if (y !== hold) begin bad++; $display("FAIL bp_y_stable cyc=%0d got=%h want=%h", i, y, hold); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", out_valid); end
        a = '{9, 0, 0, 0, 0, 0, 0, 0};
        b = '{-9, 0, 0, 0, 0, 0, 0, 0};
        push_exp(a, b, 1);
        send(9, -9);
        total++; if (y[15:0] !== 16'd9) begin bad++; $display("FAIL bp_next_y0 got=%h want=0009", y[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_latch();
        int a[8];
        int b[8];
        epol = 1'b1; eact = 1'b0; pol_s = 3'b010;
        send(50, 1);
        send(60, 2);
        total++; if (win_cnt !== 4'd2) begin bad++; $display("FAIL clr_pre_cnt got=%0d want=2", win_cnt); end
        clr = 1'b1; in_valid = 1'b1; q = {16'd100, 16'd100};
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        total++; if (win_cnt !== 4'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", win_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", out_valid); end
        a = '{1, 2, 3, 4, 0, 0, 0, 0};
        b = '{-4, -3, -2, -1, 0, 0, 0, 0};
        push_exp(a, b, 4);
        for (int i = 0; i < 4; i++) send(a[i], b[i]);
        @(posedge clk); #1;
        // Window starts as avg W=4; the mid-window changes must not take effect.
        a = '{4, 8, 12, 16, 0, 0, 0, 0};
        b = '{0, 0, 0, -4, 0, 0, 0, 0};
        pol_s = 3'b110;
        push_exp(a, b, 4);
        send(a[0], b[0]);
        epol = 1'b0; eact = 1'b1; pol_s = 3'b000;
        send(a[1], b[1]);
        total++; if (win_cnt !== 4'd2) begin bad++; $display("FAIL latch_cnt got=%0d want=2", win_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latch_early got=%b want=0", out_valid); end
        send(a[2], b[2]);
        send(a[3], b[3]);
        total++; if (y !== {16'hFFFF, 16'd10}) begin bad++; $display("FAIL latch_y got=%h want=ffff000a", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_out();
        epol = 1'b0; eact = 1'b0; pol_s = 3'b000;
        out_ready = 1'b0;
        send(123, 45);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rout_pre got=%b want=1", out_valid); end
        #3 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rout_valid got=%b want=0", out_valid); end
        total++; if (y !== '0) begin bad++; $display("FAIL rout_y got=%h want=0", y); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rout_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rout_rel_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rout_rel_valid got=%b want=0", out_valid); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_leaky();
        int a[8];
        int b[8];
        logic [15:0] want0;
`ifdef POL_LEAKY_EN
        want0 = 16'hFFF8;
`else
        want0 = 16'h0000;
`endif
        a = '{-64, 0, 0, 0, 0, 0, 0, 0};
        b = '{-1, 0, 0, 0, 0, 0, 0, 0};
        epol = 1'b0; eact = 1'b1; pol_s = 3'b000;
        push_exp(a, b, 1);
        send(-64, -1);
        total++; if (y[15:0] !== want0) begin bad++; $display("FAIL leaky_y0 got=%h want=%h", y[15:0], want0); end
        @(posedge clk); #1;
    endtask

    task automatic test_ch2();
        int a[8];
        int b[8];
        a = '{10, -1, 0, 0, 0, 0, 0, 0};
        b = '{-5, 3, 0, 0, 0, 0, 0, 0};
        epol = 1'b1; eact = 1'b0; pol_s = 3'b001;
        push_exp(a, b, 2);
        send(10, -5);
        send(-1, 3);
        total++; if (y !== {16'd3, 16'd10}) begin bad++; $display("FAIL ch2_y got=%h want=0003000a", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int a[8];
        int b[8];
        for (int w = 0; w < 8; w++) begin
            epol = 1'b1;
            eact = 1'($urandom_range(0, 1));
            pol_s = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            for (int i = 0; i < 8; i++) begin
                a[i] = int'($urandom_range(0, 65535)) - 32768;
                b[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            push_exp(a, b, 1 << pol_s[1:0]);
            for (int i = 0; i < (1 << pol_s[1:0]); i++) send(a[i], b[i]);
        end
    endtask

    initial begin
        int guard;
        test_reset();
        test_max_w4();
        test_avg_relu();
        test_backpressure();
        test_clr_latch();
        test_reset_out();
        test_leaky();
        test_ch2();
        test_back_to_back();
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
